// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, FSM states,
// write-data source and ALU function encodings, and default widths.
package cpu_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 9;

  // Opcode field values (instruction bits [8:3])
  localparam logic [5:0] OP_CPYIN  = 6'b000000;
  localparam logic [5:0] OP_CPYOUT = 6'b000001;
  localparam logic [5:0] OP_LOAD   = 6'b000010;
  localparam logic [5:0] OP_STORE  = 6'b000011;
  localparam logic [5:0] OP_ALU    = 6'b000100;  // low two bits carry the ALU function
  localparam logic [5:0] OP_BZ     = 6'b001000;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // Register-file write-data source
  localparam logic [1:0] WD_HOLD = 2'd0;
  localparam logic [1:0] WD_ALU  = 2'd1;
  localparam logic [1:0] WD_DMEM = 2'd2;

  // ALU functions
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  // Instruction class seen by the sequencer; OPC_NOP covers every undefined opcode
  typedef enum logic [2:0] {
    OPC_CPYIN,
    OPC_CPYOUT,
    OPC_LOAD,
    OPC_STORE,
    OPC_ALU,
    OPC_BZ,
    OPC_HALT,
    OPC_NOP
  } opc_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: maps the latched instruction to an
// op-class and flags undefined opcodes.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] ir,
  output opc_e               opc,
  output logic               illegal
);

  logic [5:0] op;
  assign op = ir[INSTR_W-1 -: 6];

  // Classify the opcode; anything not listed falls through to NOP
  always_comb begin
    opc = OPC_NOP;
    if (op == OP_CPYIN)                 opc = OPC_CPYIN;
    else if (op == OP_CPYOUT)           opc = OPC_CPYOUT;
    else if (op == OP_LOAD)             opc = OPC_LOAD;
    else if (op == OP_STORE)            opc = OPC_STORE;
    else if (op[5:2] == OP_ALU[5:2])    opc = OPC_ALU;
    else if (op == OP_BZ)               opc = OPC_BZ;
    else if (op == OP_HALT)             opc = OPC_HALT;
  end

  assign illegal = (opc == OPC_NOP);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer for the accumulator CPU.
// Drives the register-file controls and the instruction/data memory handshakes.
// All outputs are decoded from registered state (plus dmem_ack for the LOAD
// write strobe), so they settle after the rising edge and are stable when the
// register file samples on the falling edge.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic [15:0]        reg_val,
  input  logic               res_zero,
  output logic [2:0]         reg_sel,
  output logic               cpyin,
  output logic               cpyout,
  output logic               mem_load,
  output logic [1:0]         wd_sel,
  output logic [1:0]         alu_op,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               halted,
  output logic               illegal
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]      pc_inc;
  opc_e                 opc;
  logic                 dec_illegal;

  // Branch targets only use the low PC_W bits of the register value
  logic unused_reg_hi;
  assign unused_reg_hi = ^reg_val[15:PC_W];

  instr_decode #(.INSTR_W(INSTR_W)) u_dec (
    .ir      (ir_q),
    .opc     (opc),
    .illegal (dec_illegal)
  );

  // PC wraps silently at 2^PC_W
  assign pc_inc = pc_q + PC_W'(1);

  // State, program counter and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC and IR update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        unique case (opc)
          OPC_LOAD, OPC_STORE: state_d = ST_MEM;
          OPC_HALT:            state_d = ST_HALT;
          OPC_BZ: begin
            state_d = ST_FETCH;
            pc_d    = res_zero ? reg_val[PC_W-1:0] : pc_inc;
          end
          default: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; wd_sel stays HOLD unless a write source is explicitly wanted,
  // because the register file reloads res from write_data every falling edge.
  always_comb begin
    imem_req  = (state_q == ST_FETCH) && rst_n;  // drop the fetch request the moment reset asserts
    imem_addr = pc_q;
    reg_sel   = 3'd0;
    cpyin     = 1'b0;
    cpyout    = 1'b0;
    mem_load  = 1'b0;
    wd_sel    = WD_HOLD;
    alu_op    = ALU_ADD;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    halted    = (state_q == ST_HALT);
    illegal   = 1'b0;
    unique case (state_q)
      ST_DECODE: reg_sel = ir_q[2:0];
      ST_EXEC: begin
        reg_sel = ir_q[2:0];
        unique case (opc)
          OPC_CPYIN:  cpyin  = 1'b1;
          OPC_CPYOUT: cpyout = 1'b1;
          OPC_ALU: begin
            wd_sel = WD_ALU;
            alu_op = ir_q[INSTR_W-5 -: 2];
          end
          OPC_NOP:    illegal = dec_illegal;
          default: ;
        endcase
      end
      ST_MEM: begin
        reg_sel  = ir_q[2:0];
        dmem_req = 1'b1;
        dmem_we  = (opc == OPC_STORE);
        if (opc == OPC_LOAD && dmem_ack) begin
          mem_load = 1'b1;
          wd_sel   = WD_DMEM;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer. A per-instruction reference model
// derives the expected cycle-by-cycle outputs from the instruction's class
// and an architectural program counter.
module tb_cpu_sequencer;

  localparam int C_CPYIN = 0, C_CPYOUT = 1, C_LOAD = 2, C_STORE = 3;
  localparam int C_ALU = 4, C_BZ = 5, C_HALT = 6, C_NOP = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [8:0]  imem_rdata = '0;
  logic [15:0] reg_val = '0;
  logic        res_zero = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, cpyin, cpyout, mem_load, dmem_req, dmem_we, halted, illegal;
  logic [9:0]  imem_addr;
  logic [2:0]  reg_sel;
  logic [1:0]  wd_sel, alu_op;

  int n_chk = 0;
  int n_pass = 0;
  int m_pc = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .reg_val(reg_val), .res_zero(res_zero),
    .reg_sel(reg_sel), .cpyin(cpyin), .cpyout(cpyout), .mem_load(mem_load),
    .wd_sel(wd_sel), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .halted(halted), .illegal(illegal)
  );

  logic [24:0] obs;
  assign obs = {imem_req, imem_addr, reg_sel, cpyin, cpyout, mem_load, wd_sel, alu_op,
                dmem_req, dmem_we, halted, illegal};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [24:0] bun(bit req, int addr, int rs, bit ci, bit co, bit ml,
                                      int wd, int ao, bit dr, bit dw, bit h, bit il);
    return {req, addr[9:0], rs[2:0], ci, co, ml, wd[1:0], ao[1:0], dr, dw, h, il};
  endfunction

  // Instruction class straight from the opcode table
  function automatic int cls(logic [5:0] op);
    casez (op)
      6'b000000: return C_CPYIN;
      6'b000001: return C_CPYOUT;
      6'b000010: return C_LOAD;
      6'b000011: return C_STORE;
      6'b0001??: return C_ALU;
      6'b001000: return C_BZ;
      6'b111111: return C_HALT;
      default:   return C_NOP;
    endcase
  endfunction

  // One clock cycle: inputs already driven, compare, advance past the next rising edge
  task automatic cyc(input string tag, input logic [24:0] exp);
    #1;
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    #1;
    chk("reset", obs, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0;
  endtask

  // Run one instruction through the DUT and check every cycle.
  // iw/dw: wait cycles before imem/dmem ack; rst_at: MEM cycle at which to assert reset (-1 = none)
  task automatic run(input logic [8:0] ins, input int iw, input int dw, input bit rz,
                     input logic [15:0] rv, input int rst_at);
    logic [5:0] op;
    int r, c;
    bit ld_ack;
    op = ins[8:3];
    r  = int'(ins[2:0]);
    c  = cls(op);
    for (int i = 0; i <= iw; i++) begin
      imem_ack   = (i == iw);
      imem_rdata = (i == iw) ? ins : 9'($urandom);
      dmem_ack   = 1'($urandom);
      res_zero   = 1'($urandom);
      reg_val    = 16'($urandom);
      cyc("fetch", bun(1, m_pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    imem_ack = 1'($urandom); imem_rdata = 9'($urandom); dmem_ack = 1'($urandom);
    cyc("decode", bun(0, m_pc, r, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    res_zero = rz; reg_val = rv;
    cyc("exec", bun(0, m_pc, r, c == C_CPYIN, c == C_CPYOUT, 0,
                    (c == C_ALU) ? 1 : 0, (c == C_ALU) ? int'(op[1:0]) : 0,
                    0, 0, 0, c == C_NOP));
    if (c == C_LOAD || c == C_STORE) begin
      for (int j = 0; j <= dw; j++) begin
        dmem_ack = (j == dw);
        imem_ack = 1'($urandom);
        if (j == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_mem", obs, '0);
          repeat (2) @(posedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          m_pc = 0;
          return;
        end
        ld_ack = (c == C_LOAD) && (j == dw);
        cyc("mem", bun(0, m_pc, r, 0, 0, ld_ack, ld_ack ? 2 : 0, 0, 1, c == C_STORE, 0, 0));
      end
    end
    if (c == C_HALT) begin
      for (int k = 0; k < 3; k++) begin
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        cyc("halted", bun(0, m_pc, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
    end else if (c == C_BZ && rz) begin
      m_pc = int'(rv[9:0]);
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  initial begin
    logic [5:0] op;
    int k, iw, dw, ra;
    do_reset();

    // Directed program: CPYIN 3; ALU add 5; CPYOUT 7; HALT
    run({6'b000000, 3'd3}, 0, 0, 0, 16'h0, -1);
    run({6'b000100, 3'd5}, 0, 0, 0, 16'h0, -1);
    run({6'b000001, 3'd7}, 0, 0, 0, 16'h0, -1);
    run({6'b111111, 3'd0}, 0, 0, 0, 16'h0, -1);
    do_reset();

    // LOAD 2 with a 3-cycle dmem delay, then a STORE
    run({6'b000010, 3'd2}, 0, 3, 0, 16'h0, -1);
    run({6'b000011, 3'd6}, 1, 2, 0, 16'h0, -1);
    // BZ taken then untaken
    run({6'b001000, 3'd4}, 0, 0, 1, 16'h0123, -1);
    run({6'b001000, 3'd4}, 0, 0, 0, 16'h0123, -1);
    // Branch to the last address and let the PC wrap
    run({6'b001000, 3'd1}, 0, 0, 1, 16'hF3FF, -1);
    run({6'b000000, 3'd2}, 0, 0, 0, 16'h0, -1);
    // Undefined opcode behaves as NOP
    run({6'b010101, 3'd1}, 0, 0, 0, 16'h0, -1);
    // Reset while waiting for dmem_ack; next fetch must be from 0
    run({6'b000010, 3'd5}, 0, 5, 0, 16'h0, 2);
    run({6'b000001, 3'd1}, 0, 0, 0, 16'h0, -1);

    // Randomized instruction stream
    repeat (250) begin
      k = $urandom_range(0, 19);
      case (k)
        0, 1, 2:    op = 6'b000000;
        3, 4, 5:    op = 6'b000001;
        6, 7:       op = 6'b000010;
        8, 9:       op = 6'b000011;
        10, 11, 12: op = {4'b0001, 2'($urandom)};
        13, 14, 15: op = 6'b001000;
        16, 17, 18: begin
          op = 6'($urandom);
          while (cls(op) != C_NOP) op = 6'($urandom);
        end
        default:    op = 6'b111111;
      endcase
      iw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      dw = $urandom_range(0, 4);
      ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, dw) : -1;
      run({op, 3'($urandom)}, iw, dw, 1'($urandom), 16'($urandom), ra);
      if (cls(op) == C_HALT) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
